// File: rtl/csr_counter_if.sv
// CSR access bus for one split-address machine counter.
// Carries the strobe/address/set/clear request, the count controls and the read/ack/overflow returns.
interface csr_counter_if #(
  parameter int unsigned INC_WIDTH = 2
);
  logic                 en_i;
  logic [11:0]          addr_i;
  logic [31:0]          set_i;
  logic [31:0]          clear_i;
  logic [INC_WIDTH-1:0] inc_i;
  logic                 inhibit_i;
  logic [31:0]          read_o;
  logic                 ack_o;
  logic                 ovf_o;

  modport master (
    output en_i, addr_i, set_i, clear_i, inc_i, inhibit_i,
    input  read_o, ack_o, ovf_o
  );

  modport slave (
    input  en_i, addr_i, set_i, clear_i, inc_i, inhibit_i,
    output read_o, ack_o, ovf_o
  );
endinterface

// File: rtl/csr_counter.sv
// Machine counter CSR split over a low and a high CSR address, with set/clear writes and overflow.
// Define CSR_COUNTER_OVF_STICKY_EN to make ovf_o a sticky flag cleared by a high-half write.
module csr_counter #(
  parameter int unsigned       WIDTH       = 64,
  parameter logic [11:0]       ADDR_LO     = 12'hB00,
  parameter logic [11:0]       ADDR_HI     = 12'hB80,
  parameter int unsigned       INC_WIDTH   = 2,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  csr_counter_if.slave bus
);
  localparam int unsigned HI_W = WIDTH - 32;

  if (ADDR_LO == ADDR_HI) begin : g_addr_check
    $error("csr_counter: ADDR_LO and ADDR_HI must differ");
  end
  if (WIDTH < 33 || WIDTH > 64) begin : g_width_check
    $error("csr_counter: WIDTH must be in 33..64");
  end

  logic [WIDTH-1:0]     cnt;
  logic [WIDTH-1:0]     cnt_next;
  logic [WIDTH:0]       sum;
  logic [INC_WIDTH-1:0] inc;
  logic [31:0]          lo_new;
  logic [HI_W-1:0]      hi_new;
  logic                 hit_lo;
  logic                 hit_hi;
  logic                 wrap;
  logic                 ovf;

  assign inc    = bus.inc_i;
  assign hit_lo = bus.en_i && (bus.addr_i == ADDR_LO);
  assign hit_hi = bus.en_i && (bus.addr_i == ADDR_HI);

  assign bus.ack_o  = hit_lo || hit_hi;
  assign bus.read_o = hit_lo ? cnt[31:0] :
                      hit_hi ? 32'(cnt[WIDTH-1:32]) : 32'h0;
  assign bus.ovf_o  = ovf;

  // Set wins over clear; high-half bits beyond the counter width are dropped.
  assign lo_new = (cnt[31:0] & ~bus.clear_i) | bus.set_i;
  assign hi_new = (cnt[WIDTH-1:32] & ~bus.clear_i[HI_W-1:0]) | bus.set_i[HI_W-1:0];
  assign sum    = {1'b0, cnt} + (WIDTH+1)'(inc);

  // Any acknowledged access (even a pure read) suppresses counting that cycle.
  always_comb begin
    cnt_next = cnt;
    wrap     = 1'b0;
    if (hit_lo) begin
      cnt_next = {cnt[WIDTH-1:32], lo_new};
    end else if (hit_hi) begin
      cnt_next = {hi_new, cnt[31:0]};
    end else if (!bus.inhibit_i) begin
      cnt_next = sum[WIDTH-1:0];
      wrap     = sum[WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= RESET_VALUE;
    else       cnt <= cnt_next;
  end

`ifdef CSR_COUNTER_OVF_STICKY_EN
  // Sticky flag; only a real high-half write (non-zero set/clear) clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                     ovf <= 1'b0;
    else if (wrap)                                 ovf <= 1'b1;
    else if (hit_hi && |(bus.set_i | bus.clear_i)) ovf <= 1'b0;
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf <= 1'b0;
    else       ovf <= wrap;
  end
`endif

endmodule

// File: tb/tb_csr_counter.sv
// Directed self-checking bench for csr_counter (WIDTH=40, RESET_VALUE=5).
module tb_csr_counter;
  localparam logic [11:0] LO = 12'hB00;
  localparam logic [11:0] HI = 12'hB80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] obs;

  csr_counter_if #(.INC_WIDTH(2)) bus ();

  csr_counter #(
    .WIDTH(40), .ADDR_LO(LO), .ADDR_HI(HI), .INC_WIDTH(2), .RESET_VALUE(40'h5)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en_i = 1'b0; bus.addr_i = LO; bus.set_i = '0; bus.clear_i = '0;
    bus.inc_i = '0; bus.inhibit_i = 1'b0;
  endtask

  // Combinational read without consuming a clock edge.
  task automatic peek(input logic [11:0] a, output logic [31:0] v);
    bus.en_i = 1'b1; bus.addr_i = a; bus.set_i = '0; bus.clear_i = '0;
    #1;
    v = bus.read_o;
    bus.en_i = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] s, input logic [31:0] c);
    bus.en_i = 1'b1; bus.addr_i = a; bus.set_i = s; bus.clear_i = c;
    tick();
    bus.en_i = 1'b0; bus.set_i = '0; bus.clear_i = '0;
  endtask

  initial begin
    idle();
    // Reset
    rst = 1'b1;
    tick(); tick();
    check("ovf_in_reset", 32'(bus.ovf_o), 32'h0);
    rst = 1'b0;
    bus.en_i = 1'b1; bus.addr_i = LO; #1;
    check("ack_lo", 32'(bus.ack_o), 32'h1);
    bus.en_i = 1'b0; #1;
    peek(LO, obs); check("reset_lo", obs, 32'h5);
    peek(HI, obs); check("reset_hi", obs, 32'h0);
    check("reset_ovf", 32'(bus.ovf_o), 32'h0);

    // Count with carry from bit 31 into bit 32
    wr(LO, 32'hFFFF_FFFE, 32'h0000_0001);
    peek(LO, obs); check("load_lo", obs, 32'hFFFF_FFFE);
    bus.inc_i = 2'd1;
    tick();
    peek(LO, obs); check("count1_lo", obs, 32'hFFFF_FFFF);
    tick(); tick();
    bus.inc_i = 2'd0;
    peek(LO, obs); check("carry_lo", obs, 32'h1);
    peek(HI, obs); check("carry_hi", obs, 32'h1);

    // Multi-increment and inhibit
    wr(LO, 32'h0, 32'hFFFF_FFFF);
    wr(HI, 32'h0, 32'hFFFF_FFFF);
    bus.inc_i = 2'd3;
    repeat (4) tick();
    peek(LO, obs); check("inc3x4", obs, 32'd12);
    bus.inhibit_i = 1'b1;
    repeat (5) tick();
    peek(LO, obs); check("inhibit_hold", obs, 32'd12);
    wr(LO, 32'd100, 32'hFFFF_FFFF);
    peek(LO, obs); check("write_under_inhibit", obs, 32'd100);
    bus.inhibit_i = 1'b0;

    // Write beats a same-cycle increment; set beats clear
    bus.inc_i = 2'd2;
    wr(LO, 32'h0, 32'hFFFF_FFFF);
    bus.inc_i = 2'd0;
    peek(LO, obs); check("write_drops_inc", obs, 32'h0);
    wr(LO, 32'h0C, 32'hFFFF_FFFF);
    wr(LO, 32'h0F, 32'h0C);
    peek(LO, obs); check("set_wins", obs, 32'h0F);
    bus.inc_i = 2'd3;
    wr(LO, 32'h0, 32'h0);
    bus.inc_i = 2'd0;
    peek(LO, obs); check("read_drops_inc", obs, 32'h0F);

    // Wrap at 40 bits
    wr(LO, 32'hFFFF_FFFF, 32'h0);
    wr(HI, 32'h0000_00FF, 32'h0);
    peek(HI, obs); check("full_hi", obs, 32'h0000_00FF);
    check("ovf_before_wrap", 32'(bus.ovf_o), 32'h0);
    bus.inc_i = 2'd2;
    tick();
    bus.inc_i = 2'd0;
    check("ovf_after_wrap", 32'(bus.ovf_o), 32'h1);
    peek(LO, obs); check("wrap_lo", obs, 32'h1);
    peek(HI, obs); check("wrap_hi", obs, 32'h0);
    tick();
`ifdef CSR_COUNTER_OVF_STICKY_EN
    check("ovf_sticky_held", 32'(bus.ovf_o), 32'h1);
`else
    check("ovf_pulse_end", 32'(bus.ovf_o), 32'h0);
`endif
    wr(HI, 32'hFFFF_FF00, 32'h0);
    peek(HI, obs); check("hi_upper_ignored", obs, 32'h0);
    check("ovf_after_hi_write", 32'(bus.ovf_o), 32'h0);
    peek(LO, obs); check("lo_untouched", obs, 32'h1);

    // Decode
    bus.en_i = 1'b1; bus.addr_i = 12'hB01; bus.set_i = 32'hFFFF_FFFF; bus.inc_i = 2'd1;
    #1;
    check("nomatch_ack", 32'(bus.ack_o), 32'h0);
    check("nomatch_read", bus.read_o, 32'h0);
    tick();
    bus.en_i = 1'b0; bus.addr_i = LO; bus.set_i = '0;
    #1;
    check("en0_ack", 32'(bus.ack_o), 32'h0);
    check("en0_read", bus.read_o, 32'h0);
    tick();
    bus.inc_i = 2'd0;
    peek(LO, obs); check("nomatch_counts", obs, 32'h3);

    // Reset in the middle of an access
    bus.en_i = 1'b1; bus.addr_i = LO; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("reset_mid_access", bus.read_o, 32'h5);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
